// File: rtl/axis_window_3x3.sv
// axis_window_3x3
// Turns a raster-order AXI4-Stream pixel stream into 3x3 neighbourhoods.
// The previous two lines sit in line buffers, and one window is emitted per
// interior pixel as a flat 9-pixel bus for the downstream compare-swap
// network.
//
// Ports:
//   i_clk          single clock
//   i_aresetn      synchronous active-low reset
//   s_axis_tdata   input pixel
//   s_axis_tvalid  input pixel valid
//   s_axis_tuser   start of frame, marks pixel (0,0)
//   s_axis_tlast   end of line
//   s_axis_tready  0 in reset, 1 otherwise (the block never stalls)
//   o_window       slice k = 3*wr + wc; wr=0 is row r-2, wc=0 is column c-2,
//                  k=8 is the current pixel
//   o_valid        one-cycle strobe per window
//   o_tuser        first window of the frame (qualified by o_valid)
//   o_tlast        last window of an output line (qualified by o_valid)
//   o_line_err     one-cycle pulse on a line-length violation, aligned with
//                  o_valid timing
module axis_window_3x3 #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640
) (
  input  logic                    i_clk,
  input  logic                    i_aresetn,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tuser,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic [9*DATA_WIDTH-1:0] o_window,
  output logic                    o_valid,
  output logic                    o_tuser,
  output logic                    o_tlast,
  output logic                    o_line_err
);

  localparam int COL_W = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 2;
  localparam int WIN_W = 9 * DATA_WIDTH;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [COL_W-1:0] COL_ZERO = {COL_W{1'b0}};
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1'b1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2'd2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Control state
  state_t           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [1:0]       row_q, row_d;
  logic             first_q, first_d;   // next emitted window is frame start
  logic             tready_q, tready_d;

  // Stage 1: input register plus line-buffer read
  logic                  s1_valid_q, s1_valid_d;
  logic                  s1_emit_q, s1_emit_d;
  logic                  s1_tuser_q, s1_tuser_d;
  logic                  s1_tlast_q, s1_tlast_d;
  logic                  s1_err_q, s1_err_d;
  logic [DATA_WIDTH-1:0] s1_pix_q, s1_pix_d;
  logic [DATA_WIDTH-1:0] s1_a_q, s1_a_d;
  logic [DATA_WIDTH-1:0] s1_b_q, s1_b_d;

  // Stage 2: window register and output flags
  logic [WIN_W-1:0] win_q, win_d;
  logic             valid_q, valid_d;
  logic             tuser_q, tuser_d;
  logic             tlast_q, tlast_d;
  logic             err_q, err_d;

  // Line buffers: lb_a holds row r-1, lb_b holds row r-2
  logic [DATA_WIDTH-1:0] lb_a_q [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb_b_q [IMG_WIDTH];

  logic                  accept_s;
  logic                  sof_s;
  logic                  active_s;     // pixel is stored (not dropped in IDLE)
  logic                  line_end_s;
  logic                  err_s;
  logic                  emit_s;
  logic [COL_W-1:0]      col_eff_s;    // SOF pixel always lands at column 0
  logic [DATA_WIDTH-1:0] rd_a_s;
  logic [DATA_WIDTH-1:0] rd_b_s;
  logic                  lb_we_s;

  // Accept qualification, line-end / error detection and emission gating
  always_comb begin
    accept_s   = s_axis_tvalid & tready_q;
    sof_s      = accept_s & s_axis_tuser;
    active_s   = accept_s & (s_axis_tuser | (state_q != ST_IDLE));
    col_eff_s  = sof_s ? COL_ZERO : col_q;
    // SOF takes precedence over tlast, so the SOF pixel never ends a line.
    line_end_s = active_s & ~sof_s & (s_axis_tlast | (col_q == LAST_COL));
    err_s      = active_s & ~sof_s & (s_axis_tlast ^ (col_q == LAST_COL));
    emit_s     = active_s & ~sof_s & (state_q == ST_RUN) & (col_q >= COL_TWO);
    lb_we_s    = active_s & i_aresetn;
    rd_a_s     = lb_a_q[col_eff_s];
    rd_b_s     = lb_b_q[col_eff_s];
  end

  // Next-state logic for the frame FSM and the column / row counters
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    first_d  = first_q;
    tready_d = 1'b1;
    if (sof_s) begin
      state_d = ST_FILL;
      col_d   = COL_ONE;
      row_d   = 2'd0;
      first_d = 1'b1;
    end else if (active_s) begin
      if (line_end_s) begin
        col_d = COL_ZERO;
        if (row_q != 2'd2) begin
          row_d = row_q + 2'd1;
        end else begin
          row_d = row_q;
        end
      end else begin
        col_d = col_q + COL_ONE;
        row_d = row_q;
      end
      case (state_q)
        ST_FILL: begin
          if (line_end_s && (row_q == 2'd1)) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_FILL;
          end
        end
        ST_RUN:  state_d = ST_RUN;
        default: state_d = ST_IDLE;
      endcase
      if (emit_s) begin
        first_d = 1'b0;
      end else begin
        first_d = first_q;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Stage 1 next values; pixel and buffer read data hold during gaps
  always_comb begin
    s1_valid_d = active_s;
    s1_emit_d  = emit_s;
    s1_tuser_d = emit_s & first_q;
    s1_tlast_d = emit_s & (col_q == LAST_COL);
    s1_err_d   = err_s;
    if (active_s) begin
      s1_pix_d = s_axis_tdata;
      s1_a_d   = rd_a_s;
      s1_b_d   = rd_b_s;
    end else begin
      s1_pix_d = s1_pix_q;
      s1_a_d   = s1_a_q;
      s1_b_d   = s1_b_q;
    end
  end

  // Stage 2 next values: shift window left, new right column = {b, a, pixel}
  always_comb begin
    win_d   = win_q;
    valid_d = s1_emit_q;
    tuser_d = s1_tuser_q;
    tlast_d = s1_tlast_q;
    err_d   = s1_err_q;
    if (s1_valid_q) begin
      for (int wr = 0; wr < 3; wr++) begin
        win_d[(3*wr)*DATA_WIDTH   +: DATA_WIDTH] = win_q[(3*wr+1)*DATA_WIDTH +: DATA_WIDTH];
        win_d[(3*wr+1)*DATA_WIDTH +: DATA_WIDTH] = win_q[(3*wr+2)*DATA_WIDTH +: DATA_WIDTH];
        win_d[(3*wr+2)*DATA_WIDTH +: DATA_WIDTH] =
          (wr == 0) ? s1_b_q : ((wr == 1) ? s1_a_q : s1_pix_q);
      end
    end else begin
      win_d = win_q;
    end
  end

  // Control, pipeline and output registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (!i_aresetn) begin
      state_q    <= ST_IDLE;
      col_q      <= COL_ZERO;
      row_q      <= 2'd0;
      first_q    <= 1'b0;
      tready_q   <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_emit_q  <= 1'b0;
      s1_tuser_q <= 1'b0;
      s1_tlast_q <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_pix_q   <= {DATA_WIDTH{1'b0}};
      s1_a_q     <= {DATA_WIDTH{1'b0}};
      s1_b_q     <= {DATA_WIDTH{1'b0}};
      win_q      <= {WIN_W{1'b0}};
      valid_q    <= 1'b0;
      tuser_q    <= 1'b0;
      tlast_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      first_q    <= first_d;
      tready_q   <= tready_d;
      s1_valid_q <= s1_valid_d;
      s1_emit_q  <= s1_emit_d;
      s1_tuser_q <= s1_tuser_d;
      s1_tlast_q <= s1_tlast_d;
      s1_err_q   <= s1_err_d;
      s1_pix_q   <= s1_pix_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      win_q      <= win_d;
      valid_q    <= valid_d;
      tuser_q    <= tuser_d;
      tlast_q    <= tlast_d;
      err_q      <= err_d;
    end
  end

  // Line-buffer write; contents are never cleared, output gating hides stale data
  always_ff @(posedge i_clk) begin
    if (lb_we_s) begin
      lb_a_q[col_eff_s] <= s_axis_tdata;
      lb_b_q[col_eff_s] <= rd_a_s;
    end
  end

  assign s_axis_tready = tready_q;
  assign o_window      = win_q;
  assign o_valid       = valid_q;
  assign o_tuser       = tuser_q;
  assign o_tlast       = tlast_q;
  assign o_line_err    = err_q;

endmodule

// File: tb/tb_axis_window_3x3.sv
// Directed testbench for axis_window_3x3 with IMG_WIDTH = 5 and 4-row frames,
// pixel value = base + 10*row + col.
module tb_axis_window_3x3;

  localparam int DW = 8;
  localparam int W  = 5;

  logic          i_clk = 1'b0;
  logic          i_aresetn;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tuser;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic [9*DW-1:0] o_window;
  logic          o_valid;
  logic          o_tuser;
  logic          o_tlast;
  logic          o_line_err;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  typedef struct {
    logic [9*DW-1:0] win;
    logic            tu;
    logic            tl;
    int              cyc;
  } win_t;

  win_t win_q[$];
  int   err_cnt   = 0;
  int   err_cyc   = 0;
  int   b2b_cnt   = 0;
  logic prev_valid = 1'b0;

  axis_window_3x3 #(.DATA_WIDTH(DW), .IMG_WIDTH(W)) dut (
    .i_clk        (i_clk),
    .i_aresetn    (i_aresetn),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tuser (s_axis_tuser),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .o_window     (o_window),
    .o_valid      (o_valid),
    .o_tuser      (o_tuser),
    .o_tlast      (o_tlast),
    .o_line_err   (o_line_err)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge
  always @(negedge i_clk) begin
    if (o_valid === 1'b1) begin
      win_q.push_back('{win: o_window, tu: o_tuser, tl: o_tlast, cyc: cyc});
      if (prev_valid === 1'b1) b2b_cnt = b2b_cnt + 1;
    end
    prev_valid = o_valid;
    if (o_line_err === 1'b1) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [9*DW-1:0] exp_win(input int base, input int r, input int c);
    logic [9*DW-1:0] w;
    int v;
    w = {(9*DW){1'b0}};
    for (int wr = 0; wr < 3; wr++) begin
      for (int wc = 0; wc < 3; wc++) begin
        v = base + 10 * (r - 2 + wr) + (c - 2 + wc);
        w[(3*wr+wc)*DW +: DW] = v[DW-1:0];
      end
    end
    return w;
  endfunction

  task automatic drive(input int d, input logic u, input logic l);
    @(negedge i_clk);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d[DW-1:0];
    s_axis_tuser  = u;
    s_axis_tlast  = l;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge i_clk);
      s_axis_tvalid = 1'b0;
      s_axis_tuser  = 1'b0;
      s_axis_tlast  = 1'b0;
    end
  endtask

  task automatic send_frame(input int base, input int gap, output int c22);
    c22 = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < W; c++) begin
        drive(base + 10 * r + c, (r == 0) && (c == 0), c == W - 1);
        if (r == 2 && c == 2) c22 = cyc;
        if (gap != 0) idle(1);
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge i_clk);
    s_axis_tvalid = 1'b0;
    i_aresetn     = 1'b0;
    @(negedge i_clk);
    i_aresetn = 1'b1;
    idle(2);
  endtask

  task automatic test_reset();
    i_aresetn = 1'b0;
    idle(3);
    tests_run++;
    if ({o_valid, o_tuser, o_tlast, o_line_err} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b required 0000", {o_valid, o_tuser, o_tlast, o_line_err});
    end
    tests_run++;
    if (o_window !== {(9*DW){1'b0}}) begin
      tests_failed++;
      $display("FAIL reset_window: got %h required 0", o_window);
    end
    tests_run++;
    if (s_axis_tready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_tready: got %b required 0", s_axis_tready);
    end
    @(negedge i_clk);
    i_aresetn = 1'b1;
    idle(2);
    tests_run++;
    if (s_axis_tready !== 1'b1) begin
      tests_failed++;
      $display("FAIL tready_after_reset: got %b required 1", s_axis_tready);
    end
  endtask

  task automatic test_full_rate();
    int mark, emark, c22, r, c;
    mark = win_q.size();
    emark = err_cnt;
    send_frame(0, 0, c22);
    idle(6);
    tests_run++;
    if (win_q.size() - mark != 6) begin
      tests_failed++;
      $display("FAIL full_count: got %0d windows required 6", win_q.size() - mark);
    end
    for (int i = 0; i < 6; i++) begin
      if (mark + i < win_q.size()) begin
        r = 2 + i / 3;
        c = 2 + i % 3;
        tests_run++;
        if (win_q[mark+i].win !== exp_win(0, r, c)) begin
          tests_failed++;
          $display("FAIL full_win%0d: got %h required %h", i, win_q[mark+i].win, exp_win(0, r, c));
        end
        tests_run++;
        if ({win_q[mark+i].tu, win_q[mark+i].tl} !== {i == 0, c == W - 1}) begin
          tests_failed++;
          $display("FAIL full_flags%0d: got %b required %b", i,
                   {win_q[mark+i].tu, win_q[mark+i].tl}, {i == 0, c == W - 1});
        end
      end
    end
    if (win_q.size() > mark) begin
      tests_run++;
      if (win_q[mark].cyc - c22 != 2) begin
        tests_failed++;
        $display("FAIL full_latency: got %0d required 2", win_q[mark].cyc - c22);
      end
    end
    tests_run++;
    if (err_cnt != emark) begin
      tests_failed++;
      $display("FAIL full_no_err: got %0d pulses required 0", err_cnt - emark);
    end
  endtask

  task automatic test_gaps();
    int mark, bmark, c22, r, c;
    mark = win_q.size();
    bmark = b2b_cnt;
    send_frame(0, 1, c22);
    idle(6);
    tests_run++;
    if (win_q.size() - mark != 6) begin
      tests_failed++;
      $display("FAIL gap_count: got %0d windows required 6", win_q.size() - mark);
    end
    for (int i = 0; i < 6; i++) begin
      if (mark + i < win_q.size()) begin
        r = 2 + i / 3;
        c = 2 + i % 3;
        tests_run++;
        if ({win_q[mark+i].win, win_q[mark+i].tu, win_q[mark+i].tl} !==
            {exp_win(0, r, c), i == 0, c == W - 1}) begin
          tests_failed++;
          $display("FAIL gap_win%0d: got %h/%b%b required %h/%b%b", i, win_q[mark+i].win,
                   win_q[mark+i].tu, win_q[mark+i].tl, exp_win(0, r, c), i == 0, c == W - 1);
        end
      end
    end
    tests_run++;
    if (b2b_cnt != bmark) begin
      tests_failed++;
      $display("FAIL gap_back_to_back: got %0d consecutive valids required 0", b2b_cnt - bmark);
    end
  endtask

  task automatic test_drop_pre_sof();
    int mark, c22, r, c;
    apply_reset();
    mark = win_q.size();
    drive(99, 1'b0, 1'b0);
    drive(98, 1'b0, 1'b0);
    send_frame(0, 0, c22);
    idle(6);
    tests_run++;
    if (win_q.size() - mark != 6) begin
      tests_failed++;
      $display("FAIL drop_count: got %0d windows required 6", win_q.size() - mark);
    end
    for (int i = 0; i < 6; i++) begin
      if (mark + i < win_q.size()) begin
        r = 2 + i / 3;
        c = 2 + i % 3;
        tests_run++;
        if ({win_q[mark+i].win, win_q[mark+i].tu, win_q[mark+i].tl} !==
            {exp_win(0, r, c), i == 0, c == W - 1}) begin
          tests_failed++;
          $display("FAIL drop_win%0d: got %h/%b%b required %h/%b%b", i, win_q[mark+i].win,
                   win_q[mark+i].tu, win_q[mark+i].tl, exp_win(0, r, c), i == 0, c == W - 1);
        end
      end
    end
    if (win_q.size() > mark) begin
      tests_run++;
      if (win_q[mark].cyc - c22 != 2) begin
        tests_failed++;
        $display("FAIL drop_latency: got %0d required 2", win_q[mark].cyc - c22);
      end
    end
  endtask

  task automatic test_line_err();
    int mark, emark, c13, c22, ntl;
    mark = win_q.size();
    emark = err_cnt;
    c13 = 0;
    c22 = 0;
    for (int c = 0; c < W; c++) drive(c, c == 0, c == W - 1);
    for (int c = 0; c < 4; c++) begin
      drive(10 + c, 1'b0, c == 3);
      if (c == 3) c13 = cyc;
    end
    for (int r = 2; r < 4; r++) begin
      for (int c = 0; c < W; c++) begin
        drive(10 * r + c, 1'b0, c == W - 1);
        if (r == 2 && c == 2) c22 = cyc;
      end
    end
    idle(6);
    tests_run++;
    if (err_cnt - emark != 1) begin
      tests_failed++;
      $display("FAIL err_pulses: got %0d required 1", err_cnt - emark);
    end
    tests_run++;
    if (err_cyc - c13 != 2) begin
      tests_failed++;
      $display("FAIL err_latency: got %0d required 2", err_cyc - c13);
    end
    tests_run++;
    if (win_q.size() - mark != 6) begin
      tests_failed++;
      $display("FAIL err_count: got %0d windows required 6", win_q.size() - mark);
    end
    if (win_q.size() > mark) begin
      tests_run++;
      if ({win_q[mark].win, win_q[mark].tu} !== {exp_win(0, 2, 2), 1'b1}) begin
        tests_failed++;
        $display("FAIL err_first_win: got %h/%b required %h/1", win_q[mark].win,
                 win_q[mark].tu, exp_win(0, 2, 2));
      end
      tests_run++;
      if (win_q[mark].cyc - c22 != 2) begin
        tests_failed++;
        $display("FAIL err_first_latency: got %0d required 2", win_q[mark].cyc - c22);
      end
    end
    ntl = 0;
    for (int i = mark; i < win_q.size(); i++) if (win_q[i].tl === 1'b1) ntl++;
    tests_run++;
    if (ntl != 2) begin
      tests_failed++;
      $display("FAIL err_tlast_count: got %0d required 2", ntl);
    end
  endtask

  task automatic test_sof_restart();
    int mark, c22, r, c, ntu;
    mark = win_q.size();
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < W; cc++) drive(10 * rr + cc, (rr == 0) && (cc == 0), cc == W - 1);
    drive(30, 1'b0, 1'b0);
    send_frame(100, 0, c22);
    idle(6);
    tests_run++;
    if (win_q.size() - mark != 9) begin
      tests_failed++;
      $display("FAIL sof_count: got %0d windows required 9", win_q.size() - mark);
    end
    for (int i = 0; i < 9; i++) begin
      if (mark + i < win_q.size()) begin
        if (i < 3) begin
          r = 2;
          c = 2 + i;
        end else begin
          r = 2 + (i - 3) / 3;
          c = 2 + (i - 3) % 3;
        end
        tests_run++;
        if (win_q[mark+i].win !== exp_win((i < 3) ? 0 : 100, r, c)) begin
          tests_failed++;
          $display("FAIL sof_win%0d: got %h required %h", i, win_q[mark+i].win,
                   exp_win((i < 3) ? 0 : 100, r, c));
        end
      end
    end
    if (win_q.size() > mark + 3) begin
      tests_run++;
      if ({win_q[mark+3].tu, win_q[mark+3].cyc - c22} !== {1'b1, 32'sd2}) begin
        tests_failed++;
        $display("FAIL sof_new_first: got tuser %b latency %0d required tuser 1 latency 2",
                 win_q[mark+3].tu, win_q[mark+3].cyc - c22);
      end
    end
    ntu = 0;
    for (int i = mark; i < win_q.size(); i++) if (win_q[i].tu === 1'b1) ntu++;
    tests_run++;
    if (ntu != 2) begin
      tests_failed++;
      $display("FAIL sof_tuser_count: got %0d required 2", ntu);
    end
  endtask

  task automatic test_reset_mid_run();
    int mark, mark2, c22;
    mark = win_q.size();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < ((r == 2) ? 4 : W); c++) drive(10 * r + c, (r == 0) && (c == 0), c == W - 1);
    @(negedge i_clk);
    s_axis_tvalid = 1'b0;
    i_aresetn     = 1'b0;
    @(negedge i_clk);
    tests_run++;
    if ({o_valid, o_tuser, o_tlast, o_line_err, s_axis_tready} !== 5'b00000) begin
      tests_failed++;
      $display("FAIL midrst_flags: got %b required 00000",
               {o_valid, o_tuser, o_tlast, o_line_err, s_axis_tready});
    end
    tests_run++;
    if (o_window !== {(9*DW){1'b0}}) begin
      tests_failed++;
      $display("FAIL midrst_window: got %h required 0", o_window);
    end
    tests_run++;
    if (win_q.size() - mark != 1) begin
      tests_failed++;
      $display("FAIL midrst_inflight: got %0d windows required 1", win_q.size() - mark);
    end
    i_aresetn = 1'b1;
    idle(2);
    mark2 = win_q.size();
    drive(24, 1'b0, 1'b1);
    for (int c = 0; c < W; c++) drive(30 + c, 1'b0, c == W - 1);
    idle(4);
    tests_run++;
    if (win_q.size() != mark2) begin
      tests_failed++;
      $display("FAIL midrst_no_sof_output: got %0d windows required 0", win_q.size() - mark2);
    end
    send_frame(50, 0, c22);
    idle(6);
    tests_run++;
    if (win_q.size() - mark2 != 6) begin
      tests_failed++;
      $display("FAIL midrst_count: got %0d windows required 6", win_q.size() - mark2);
    end
    if (win_q.size() > mark2) begin
      tests_run++;
      if ({win_q[mark2].win, win_q[mark2].tu} !== {exp_win(50, 2, 2), 1'b1}) begin
        tests_failed++;
        $display("FAIL midrst_first_win: got %h/%b required %h/1", win_q[mark2].win,
                 win_q[mark2].tu, exp_win(50, 2, 2));
      end
      tests_run++;
      if (win_q[mark2].cyc - c22 != 2) begin
        tests_failed++;
        $display("FAIL midrst_latency: got %0d required 2", win_q[mark2].cyc - c22);
      end
    end
  endtask

  initial begin
    i_aresetn     = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = {DW{1'b0}};
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
    test_reset();
    test_full_rate();
    test_gaps();
    test_drop_pre_sof();
    test_line_err();
    test_sof_restart();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
